// File: rtl/cheri_pkg.sv
// Shared capability types and constants for the CHERIoT register files.
package cheri_pkg;

  localparam int unsigned RF_NRSV_MAX = 3;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned TOP_W    = 9;
  localparam int unsigned BOT_W    = 9;
  localparam int unsigned OTYPE_W  = 3;
  localparam int unsigned CPERMS_W = 6;

  typedef struct packed {
    logic                valid;
    logic [1:0]          top_cor;
    logic                base_cor;
    logic [EXP_W-1:0]    exp;
    logic [TOP_W-1:0]    top;
    logic [BOT_W-1:0]    base;
    logic [OTYPE_W-1:0]  otype;
    logic [CPERMS_W-1:0] cperms;
  } reg_cap_t;

  localparam int unsigned REG_CAP_W = $bits(reg_cap_t);

  localparam reg_cap_t NULL_REG_CAP = '{
    valid:    1'b0,
    top_cor:  2'b00,
    base_cor: 1'b0,
    exp:      5'd24,
    top:      9'h100,
    base:     '0,
    otype:    '0,
    cperms:   '0
  };

  function automatic logic [REG_CAP_W-1:0] reg2vec(input reg_cap_t cap);
    return cap;
  endfunction

endpackage

// File: rtl/cheri_rsv_cnt.sv
// Per-register outstanding-load counter; saturates at NRSV and 0, flagging
// over/underflow attempts on err_o for the cycle they occur.
module cheri_rsv_cnt import cheri_pkg::*; #(
  parameter int unsigned NRSV = RF_NRSV_MAX,
  parameter int unsigned CW   = $clog2(NRSV + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CW'(NRSV)) err_o = 1'b1;
      else                    cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cheri_regfile_mp.sv
// Multi-port capability register file with per-register reservation counters.
// Optional write read-back / shadow-counter checker: CHERI_RF_RDBK_EN.
module cheri_regfile_mp import cheri_pkg::*; #(
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NCAPS      = 32,
  parameter int unsigned NRD        = 2,
  parameter int unsigned NWR        = 2,
  parameter int unsigned NRSV       = RF_NRSV_MAX,
  parameter bit          CheriPPLBC = 1'b1,
  parameter bit          TRVKBypass = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD-1:0][4:0]   raddr_i,
  output logic [NRD-1:0][31:0]  rdata_o,
  output reg_cap_t [NRD-1:0]    rcap_o,
  input  logic [NWR-1:0][4:0]   waddr_i,
  input  logic [NWR-1:0][31:0]  wdata_i,
  input  reg_cap_t [NWR-1:0]    wcap_i,
  input  logic [NWR-1:0]        we_i,
  input  logic [4:0]            trsv_addr_i,
  input  logic                  trsv_en_i,
  input  logic [4:0]            trvk_addr_i,
  input  logic                  trvk_en_i,
  input  logic                  trvk_clrtag_i,
  output logic [31:0]           reg_rdy_o,
  output logic                  rsv_err_o,
  output logic                  alert_o
);

  localparam int unsigned CW = $clog2(NRSV + 1);

  function automatic logic is_gpr(input logic [4:0] a);
    return (a != '0) && (32'(a) < NREGS);
  endfunction

  function automatic logic is_cap(input logic [4:0] a);
    return (a != '0) && (32'(a) < NCAPS);
  endfunction

  logic [31:0] rf_data   [NREGS];
  logic [31:0] rf_data_d [NREGS];
  reg_cap_t    rf_cap    [NCAPS];
  reg_cap_t    rf_cap_d  [NCAPS];

  logic rsv_act, rvk_act, clr_act;

  assign rsv_act = CheriPPLBC && trsv_en_i && is_cap(trsv_addr_i);
  assign rvk_act = CheriPPLBC && trvk_en_i && is_cap(trvk_addr_i);
  assign clr_act = rvk_act && trvk_clrtag_i;

  // Ascending port order lets the highest-index port win; the tag clear is
  // applied last so it overrides a same-cycle write's valid bit.
  always_comb begin
    rf_data_d = rf_data;
    rf_cap_d  = rf_cap;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (we_i[p]) begin
        if (is_gpr(waddr_i[p])) rf_data_d[waddr_i[p]] = wdata_i[p];
        if (is_cap(waddr_i[p])) rf_cap_d[waddr_i[p]]  = wcap_i[p];
      end
    end
    if (clr_act) rf_cap_d[trvk_addr_i].valid = 1'b0;
    rf_data_d[0] = '0;
    rf_cap_d[0]  = NULL_REG_CAP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_data[i] <= '0;
      for (int unsigned i = 0; i < NCAPS; i++) rf_cap[i]  <= NULL_REG_CAP;
    end else begin
      rf_data <= rf_data_d;
      rf_cap  <= rf_cap_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NRD; r++) begin
      rdata_o[r] = '0;
      rcap_o[r]  = NULL_REG_CAP;
      if (is_gpr(raddr_i[r])) rdata_o[r] = rf_data[raddr_i[r]];
      if (is_cap(raddr_i[r])) rcap_o[r]  = rf_cap[raddr_i[r]];
      if (TRVKBypass && clr_act && (raddr_i[r] == trvk_addr_i)) rcap_o[r].valid = 1'b0;
    end
  end

  logic [NCAPS-1:0] inc, dec, cnt_err;
  logic [CW-1:0]    cnt [NCAPS];

  assign inc[0]     = 1'b0;
  assign dec[0]     = 1'b0;
  assign cnt_err[0] = 1'b0;
  assign cnt[0]     = '0;

  for (genvar i = 1; i < NCAPS; i++) begin : g_cnt
    assign inc[i] = rsv_act && (trsv_addr_i == 5'(i));
    assign dec[i] = rvk_act && (trvk_addr_i == 5'(i));

    cheri_rsv_cnt #(
      .NRSV (NRSV),
      .CW   (CW)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[i]),
      .dec_i (dec[i]),
      .cnt_o (cnt[i]),
      .err_o (cnt_err[i])
    );
  end

  logic rsv_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)         rsv_err_q <= 1'b0;
    else if (|cnt_err) rsv_err_q <= 1'b1;
  end

  assign rsv_err_o = rsv_err_q;

  // A lone completion makes the register ready in the same cycle it is seen.
  always_comb begin
    reg_rdy_o = '1;
    for (int unsigned i = 1; i < NCAPS; i++) begin
      reg_rdy_o[i] = (cnt[i] == '0);
      if (TRVKBypass && dec[i] && !inc[i]) reg_rdy_o[i] = (cnt[i] <= CW'(1));
    end
  end

`ifdef CHERI_RF_RDBK_EN
  logic [NWR-1:0]        we_q;
  logic [NWR-1:0][4:0]   waddr_q;
  logic [NWR-1:0][31:0]  wdata_q;
  reg_cap_t [NWR-1:0]    wcap_q;
  logic                  clr_q;
  logic [4:0]            clr_addr_q;
  logic [NCAPS-1:0]      inc_q, dec_q, cnt_err_q, shd_err;
  logic [CW-1:0]         cnt_q [NCAPS];
  logic [CW-1:0]         shd   [NCAPS];
  logic                  mism, alert_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wcap_q     <= '0;
      clr_q      <= 1'b0;
      clr_addr_q <= '0;
      inc_q      <= '0;
      dec_q      <= '0;
      cnt_err_q  <= '0;
      for (int unsigned i = 0; i < NCAPS; i++) cnt_q[i] <= '0;
      alert_q    <= 1'b0;
    end else begin
      we_q       <= we_i;
      waddr_q    <= waddr_i;
      wdata_q    <= wdata_i;
      wcap_q     <= wcap_i;
      clr_q      <= clr_act;
      clr_addr_q <= trvk_addr_i;
      inc_q      <= inc;
      dec_q      <= dec;
      cnt_err_q  <= cnt_err;
      cnt_q      <= cnt;
      alert_q    <= mism;
    end
  end

  assign shd[0]     = '0;
  assign shd_err[0] = 1'b0;

  // Shadow counters replay the flopped requests, so they track cnt one cycle late.
  for (genvar i = 1; i < NCAPS; i++) begin : g_shd
    cheri_rsv_cnt #(
      .NRSV (NRSV),
      .CW   (CW)
    ) u_shd (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc_q[i]),
      .dec_i (dec_q[i]),
      .cnt_o (shd[i]),
      .err_o (shd_err[i])
    );
  end

  always_comb begin
    mism = 1'b0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (we_q[p] && is_gpr(waddr_q[p])) begin
        logic shadowed;
        shadowed = 1'b0;
        for (int unsigned q = p + 1; q < NWR; q++) begin
          if (we_q[q] && (waddr_q[q] == waddr_q[p])) shadowed = 1'b1;
        end
        if (!shadowed) begin
          if (rf_data[waddr_q[p]] != wdata_q[p]) mism = 1'b1;
          if (is_cap(waddr_q[p]) && !(clr_q && (clr_addr_q == waddr_q[p])) &&
              (reg2vec(rf_cap[waddr_q[p]]) != reg2vec(wcap_q[p]))) mism = 1'b1;
        end
      end
    end
    for (int unsigned i = 1; i < NCAPS; i++) begin
      if ((shd[i] != cnt_q[i]) || (shd_err[i] != cnt_err_q[i])) mism = 1'b1;
    end
  end

  assign alert_o = alert_q;
`else
  assign alert_o = 1'b0;
`endif

endmodule

// File: tb/tb_cheri_regfile_mp.sv
// Directed vector bench for cheri_regfile_mp (default parameters).
module tb_cheri_regfile_mp;
  import cheri_pkg::*;

  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD-1:0][4:0]  raddr;
  logic [NRD-1:0][31:0] rdata;
  reg_cap_t [NRD-1:0]   rcap;
  logic [NWR-1:0][4:0]  waddr;
  logic [NWR-1:0][31:0] wdata;
  reg_cap_t [NWR-1:0]   wcap;
  logic [NWR-1:0]       we;
  logic [4:0]           trsv_addr, trvk_addr;
  logic                 trsv_en, trvk_en, trvk_clrtag;
  logic [31:0]          reg_rdy;
  logic                 rsv_err, alert;

  always #5 clk = ~clk;

  cheri_regfile_mp #(
    .NREGS (32),
    .NCAPS (32),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rcap_o        (rcap),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .wcap_i        (wcap),
    .we_i          (we),
    .trsv_addr_i   (trsv_addr),
    .trsv_en_i     (trsv_en),
    .trvk_addr_i   (trvk_addr),
    .trvk_en_i     (trvk_en),
    .trvk_clrtag_i (trvk_clrtag),
    .reg_rdy_o     (reg_rdy),
    .rsv_err_o     (rsv_err),
    .alert_o       (alert)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    reg_cap_t    wc0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    reg_cap_t    wc1;
    logic        rsv;
    logic [4:0]  rsva;
    logic        rvk;
    logic [4:0]  rvka;
    logic        clr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] erd0;
    reg_cap_t    erc0;
    logic [31:0] erd1;
    reg_cap_t    erc1;
    logic [31:0] erdy;
    logic        eerr;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  vec_t        vt[$];
  reg_cap_t    N, A, B, AN, BN;

  function automatic vec_t v(input logic r, input logic [1:0] w,
      input logic [4:0] wa0, input logic [31:0] wd0, input reg_cap_t wc0,
      input logic [4:0] wa1, input logic [31:0] wd1, input reg_cap_t wc1,
      input logic rsv, input logic [4:0] rsva, input logic rvk, input logic [4:0] rvka, input logic clr,
      input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [31:0] erd0, input reg_cap_t erc0, input logic [31:0] erd1, input reg_cap_t erc1,
      input logic [31:0] erdy, input logic eerr);
    vec_t t;
    t.rst = r;   t.we = w;
    t.wa0 = wa0; t.wd0 = wd0; t.wc0 = wc0;
    t.wa1 = wa1; t.wd1 = wd1; t.wc1 = wc1;
    t.rsv = rsv; t.rsva = rsva; t.rvk = rvk; t.rvka = rvka; t.clr = clr;
    t.ra0 = ra0; t.ra1 = ra1;
    t.erd0 = erd0; t.erc0 = erc0; t.erd1 = erd1; t.erc1 = erc1;
    t.erdy = erdy; t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; waddr = '0; wdata = '0;
    wcap[0] = NULL_REG_CAP; wcap[1] = NULL_REG_CAP;
    trsv_en = 1'b0; trsv_addr = '0; trvk_en = 1'b0; trvk_addr = '0; trvk_clrtag = 1'b0;
    raddr = '0;
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; we = t.we;
    waddr[0] = t.wa0; wdata[0] = t.wd0; wcap[0] = t.wc0;
    waddr[1] = t.wa1; wdata[1] = t.wd1; wcap[1] = t.wc1;
    trsv_en = t.rsv; trsv_addr = t.rsva;
    trvk_en = t.rvk; trvk_addr = t.rvka; trvk_clrtag = t.clr;
    raddr[0] = t.ra0; raddr[1] = t.ra1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    N  = NULL_REG_CAP;
    A  = '{valid: 1'b1, top_cor: 2'b01, base_cor: 1'b1, exp: 5'd3, top: 9'h1ff,
           base: 9'h010, otype: 3'd0, cperms: 6'h3f};
    B  = '{valid: 1'b1, top_cor: 2'b10, base_cor: 1'b0, exp: 5'd7, top: 9'h0ab,
           base: 9'h001, otype: 3'd2, cperms: 6'h15};
    AN = A; AN.valid = 1'b0;
    BN = B; BN.valid = 1'b0;

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    raddr[0] = 5'd5; raddr[1] = 5'd5;
    #2;
    n_vec++;
    chk("reset rdata0", -1, 64'(rdata[0]), 64'h0);
    chk("reset rdata1", -1, 64'(rdata[1]), 64'h0);
    chk("reset rcap0", -1, 64'(reg2vec(rcap[0])), 64'(reg2vec(NULL_REG_CAP)));
    chk("reset rcap1", -1, 64'(reg2vec(rcap[1])), 64'(reg2vec(NULL_REG_CAP)));
    chk("reset reg_rdy", -1, 64'(reg_rdy), 64'(ONES));
    chk("reset rsv_err", -1, 64'(rsv_err), 64'h0);
    chk("reset alert", -1, 64'(alert), 64'h0);

    //        rst we     wa0   wd0            wc0 wa1   wd1       wc1 rsv rsva  rvk rvka  clr ra0   ra1   erd0           erc0 erd1           erc1 erdy           eerr
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd5, 5'd5, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b11, 5'd7, 32'h1111,     A, 5'd7, 32'h2222, B, 0, 5'd0, 0, 5'd0, 0, 5'd7, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd7, 5'd3, 32'h2222,     B,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b01, 5'd3, 32'hDEADBEEF, A, 5'd3, 32'h5555, B, 0, 5'd0, 0, 5'd0, 0, 5'd3, 5'd7, 32'h0,        N,  32'h2222,     B,  ONES,          0));
    vt.push_back(v(0, 2'b11, 5'd0, 32'h1234,     A, 5'd0, 32'hFFFF, B, 0, 5'd0, 0, 5'd0, 0, 5'd3, 5'd0, 32'hDEADBEEF, A,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd3, 32'h0,        N,  32'hDEADBEEF, A,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 0, 5'd0, 0, 5'd9, 5'd9, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd9, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  32'hFFFF_FDFF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd12,0, 5'd0, 0, 5'd7, 5'd0, 32'h2222,     B,  32'h0,        N,  ONES,          1));
    vt.push_back(v(1, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd7, 5'd0, 32'h2222,     B,  32'h0,        N,  32'hFFFF_EFFF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd7, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 1, 5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd12,0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          0));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b01, 5'd4, 32'h44,       A, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd4, 1, 5'd4, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd4, 5'd0, 32'h44,       AN, 32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b01, 5'd6, 32'h66,       B, 5'd0, 32'h0,    N, 1, 5'd6, 0, 5'd0, 0, 5'd6, 5'd0, 32'h0,        N,  32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd6, 5'd6, 32'h66,       B,  32'h66,       B,  32'hFFFF_FFBF, 1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd6, 1, 5'd6, 5'd4, 32'h66,       BN, 32'h44,       AN, ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'h66,       BN, 32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b10, 5'd0, 32'h0,        N, 5'd6, 32'h6060, B, 0, 5'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'h66,       BN, 32'h0,        N,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 1, 5'd6, 0, 5'd6, 5'd6, 32'h6060,     B,  32'h6060,     B,  ONES,          1));
    vt.push_back(v(0, 2'b00, 5'd0, 32'h0,        N, 5'd0, 32'h0,    N, 0, 5'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'h6060,     B,  32'h0,        N,  ONES,          1));

    foreach (vt[i]) begin
      @(negedge clk);
      apply(vt[i]);
      #2;
      n_vec++;
      chk("rdata0", i, 64'(rdata[0]), 64'(vt[i].erd0));
      chk("rdata1", i, 64'(rdata[1]), 64'(vt[i].erd1));
      chk("rcap0", i, 64'(reg2vec(rcap[0])), 64'(reg2vec(vt[i].erc0)));
      chk("rcap1", i, 64'(reg2vec(rcap[1])), 64'(reg2vec(vt[i].erc1)));
      chk("reg_rdy", i, 64'(reg_rdy), 64'(vt[i].erdy));
      chk("rsv_err", i, 64'(rsv_err), 64'(vt[i].eerr));
      chk("alert", i, 64'(alert), 64'h0);
    end

    @(negedge clk);
    idle();

`ifdef CHERI_RF_RDBK_EN
    @(negedge clk);
    we[0] = 1'b1; waddr[0] = 5'd10; wdata[0] = 32'hA0; wcap[0] = A;
    @(posedge clk);
    #1;
    force dut.rf_cap[10] = AN;
    @(negedge clk);
    release dut.rf_cap[10];
    idle();
    #1;
    n_vec++;
    chk("rdbk alert before", -2, 64'(alert), 64'h0);
    @(negedge clk);
    #1;
    n_vec++;
    chk("rdbk alert pulse", -2, 64'(alert), 64'h1);
    @(negedge clk);
    #1;
    n_vec++;
    chk("rdbk alert cleared", -2, 64'(alert), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
